wb_i2c_write_sequencer: RTL and testbench

//  Wishbone master that turns one request (bus id, 7-bit slave addr, data byte) into the full

---
 rtl/wb_i2c_write_sequencer_if.sv | 32 +++
 rtl/wb_i2c_write_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_i2c_write_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_i2c_write_sequencer_if.sv
// Client request/status and Wishbone signals between the write sequencer and its neighbours.
// The master modport is the sequencer's view; the slave modport is the client/controller view.
interface wb_i2c_write_sequencer_if #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
) ();
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [7:0]               req_bus_i;
  logic [6:0]               req_addr_i;
  logic [7:0]               req_data_i;
  logic                     done_o;
  logic [1:0]               status_o;
  logic                     cyc_o;
  logic                     stb_o;
  logic                     we_o;
  logic [WB_ADDR_WIDTH-1:0] adr_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     ack_i;
  logic                     irq_i;

  modport master (
    input  req_valid_i, req_bus_i, req_addr_i, req_data_i, dat_i, ack_i, irq_i,
    output req_ready_o, done_o, status_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output req_valid_i, req_bus_i, req_addr_i, req_data_i, dat_i, ack_i, irq_i,
    input  req_ready_o, done_o, status_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/wb_i2c_write_sequencer.sv
// Wishbone master that drives the IICMB controller through a complete single-byte I2C write
// (Set Bus, Start, address, data, Stop) for each accepted request and reports the outcome.
module wb_i2c_write_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic rst_i,
  wb_i2c_write_sequencer_if.master sif
);

  localparam logic [2:0] S_EN_CORE  = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_WB_REQ   = 3'd2;
  localparam logic [2:0] S_WB_ACK   = 3'd3;
  localparam logic [2:0] S_WAIT_IRQ = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [3:0] STEP_DPR_BUS  = 4'd0;
  localparam logic [3:0] STEP_SET_BUS  = 4'd1;
  localparam logic [3:0] STEP_START    = 4'd2;
  localparam logic [3:0] STEP_DPR_ADDR = 4'd3;
  localparam logic [3:0] STEP_WR_ADDR  = 4'd4;
  localparam logic [3:0] STEP_DPR_DATA = 4'd5;
  localparam logic [3:0] STEP_WR_DATA  = 4'd6;
  localparam logic [3:0] STEP_STOP     = 4'd7;
  localparam logic [3:0] STEP_CSR      = 4'd8;

  // Steps that write CMDR and therefore wait for the controller interrupt.
  localparam logic [15:0] CMD_STEP_MASK = 16'h00D6;

  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [7:0] CMD_START   = 8'h04;
  localparam logic [7:0] CMD_STOP    = 8'h05;
  localparam logic [7:0] CMD_SET_BUS = 8'h06;
  localparam logic [7:0] CSR_ENABLE  = 8'hC0;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NAK     = 2'b01;
  localparam logic [1:0] ST_ERR     = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]               state_reg;
  logic [3:0]               step_reg;
  logic                     rd_reg;
  logic                     nak_reg;
  logic [7:0]               bus_reg;
  logic [6:0]               addr_reg;
  logic [7:0]               data_reg;
  logic [TMO_W-1:0]         tmo_reg;
  logic [3:0]               flags_reg;
  logic                     cyc_reg;
  logic                     stb_reg;
  logic                     we_reg;
  logic [WB_ADDR_WIDTH-1:0] adr_reg;
  logic [WB_DATA_WIDTH-1:0] dat_reg;
  logic                     done_reg;
  logic [1:0]               status_reg;
  logic                     ready_reg;

  logic [15:0]              step_hit;
  logic                     step_is_cmd;
  logic                     step_nak_ok;
  logic [WB_ADDR_WIDTH-1:0] step_adr;
  logic [7:0]               step_dat;

  // flags_reg holds CMDR[7:4] = {DON, NAK, AL, ERR} from the latest status read.
  logic flag_don, flag_nak, flag_al, flag_err;
  assign {flag_don, flag_nak, flag_al, flag_err} = flags_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_step_dec
      assign step_hit[gi] = (step_reg == 4'(gi));
    end
  endgenerate

  assign step_is_cmd = |(step_hit & CMD_STEP_MASK);
  assign step_nak_ok = step_hit[STEP_WR_ADDR] | step_hit[STEP_WR_DATA];

  always_comb begin
    step_adr = ADR_CMDR;
    step_dat = CMD_STOP;
    case (step_reg)
      STEP_DPR_BUS:  begin step_adr = ADR_DPR;  step_dat = bus_reg;          end
      STEP_SET_BUS:  begin step_adr = ADR_CMDR; step_dat = CMD_SET_BUS;      end
      STEP_START:    begin step_adr = ADR_CMDR; step_dat = CMD_START;        end
      STEP_DPR_ADDR: begin step_adr = ADR_DPR;  step_dat = {addr_reg, 1'b0}; end
      STEP_WR_ADDR:  begin step_adr = ADR_CMDR; step_dat = CMD_WRITE;        end
      STEP_DPR_DATA: begin step_adr = ADR_DPR;  step_dat = data_reg;         end
      STEP_WR_DATA:  begin step_adr = ADR_CMDR; step_dat = CMD_WRITE;        end
      STEP_STOP:     begin step_adr = ADR_CMDR; step_dat = CMD_STOP;         end
      STEP_CSR:      begin step_adr = ADR_CSR;  step_dat = CSR_ENABLE;       end
      default:       begin step_adr = ADR_CMDR; step_dat = CMD_STOP;         end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg  <= S_EN_CORE;
      step_reg   <= STEP_DPR_BUS;
      rd_reg     <= 1'b0;
      nak_reg    <= 1'b0;
      bus_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      tmo_reg    <= '0;
      flags_reg  <= '0;
      cyc_reg    <= 1'b0;
      stb_reg    <= 1'b0;
      we_reg     <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      done_reg   <= 1'b0;
      status_reg <= ST_OK;
      ready_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_EN_CORE: begin
          step_reg  <= STEP_CSR;
          rd_reg    <= 1'b0;
          state_reg <= S_WB_REQ;
        end

        S_IDLE: begin
          if (sif.req_valid_i) begin
            bus_reg   <= sif.req_bus_i;
            addr_reg  <= sif.req_addr_i;
            data_reg  <= sif.req_data_i;
            step_reg  <= STEP_DPR_BUS;
            rd_reg    <= 1'b0;
            nak_reg   <= 1'b0;
            ready_reg <= 1'b0;
            state_reg <= S_WB_REQ;
          end
        end

        // Every status read targets CMDR; only writes follow the step table.
        S_WB_REQ: begin
          cyc_reg   <= 1'b1;
          stb_reg   <= 1'b1;
          we_reg    <= ~rd_reg;
          adr_reg   <= rd_reg ? ADR_CMDR : step_adr;
          dat_reg   <= rd_reg ? '0 : WB_DATA_WIDTH'(step_dat);
          state_reg <= S_WB_ACK;
        end

        S_WB_ACK: begin
          if (sif.ack_i) begin
            cyc_reg <= 1'b0;
            stb_reg <= 1'b0;
            we_reg  <= 1'b0;
            if (rd_reg) begin
              flags_reg <= sif.dat_i[7:4];
              state_reg <= S_CHECK;
            end else if (step_hit[STEP_CSR]) begin
              ready_reg <= 1'b1;
              state_reg <= S_IDLE;
            end else if (step_is_cmd) begin
              tmo_reg   <= '0;
              state_reg <= S_WAIT_IRQ;
            end else begin
              step_reg  <= step_reg + 4'd1;
              state_reg <= S_WB_REQ;
            end
          end
        end

        S_WAIT_IRQ: begin
          if (sif.irq_i) begin
            rd_reg    <= 1'b1;
            state_reg <= S_WB_REQ;
          end else if (tmo_reg == TMO_LAST) begin
            status_reg <= ST_TIMEOUT;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end

        // Precedence: AL/ERR abort without Stop, then NAK, then DON.
        S_CHECK: begin
          rd_reg <= 1'b0;
          if (flag_al || flag_err) begin
            status_reg <= ST_ERR;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else if (flag_nak) begin
            if (step_nak_ok) begin
              nak_reg   <= 1'b1;
              step_reg  <= STEP_STOP;
              state_reg <= S_WB_REQ;
            end else begin
              status_reg <= ST_ERR;
              done_reg   <= 1'b1;
              state_reg  <= S_DONE;
            end
          end else if (!flag_don) begin
            status_reg <= ST_ERR;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else if (step_hit[STEP_STOP]) begin
            status_reg <= nak_reg ? ST_NAK : ST_OK;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            step_reg  <= step_reg + 4'd1;
            state_reg <= S_WB_REQ;
          end
        end

        S_DONE: begin
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_EN_CORE;
        end
      endcase
    end
  end

  assign sif.req_ready_o = ready_reg;
  assign sif.done_o      = done_reg;
  assign sif.status_o    = status_reg;
  assign sif.cyc_o       = cyc_reg;
  assign sif.stb_o       = stb_reg;
  assign sif.we_o        = we_reg;
  assign sif.adr_o       = adr_reg;
  assign sif.dat_o       = dat_reg;

endmodule

// File: tb/tb_wb_i2c_write_sequencer.sv
// Directed bench for wb_i2c_write_sequencer: a behavioural IICMB/Wishbone slave records every
// access while a table of requests and a few hand-written sequences check trace and status.
module tb_wb_i2c_write_sequencer;

  typedef logic [12:0][10:0] trace_t;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic [6:0] a;
    logic [7:0] d;
    int         dly;
    logic [7:0] resp [5];
    int         tlen;
    trace_t     trace;
    logic [1:0] st;
  } vec_t;

  localparam logic [10:0] RD_CMDR = {1'b0, 2'd2, 8'h00};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc_count = 0;

  logic [10:0] log_q [$];
  logic [7:0]  resp_q [$];
  int          ack_dly = 0;
  int          irq_dly = 3;
  logic        irq_en = 1'b1;
  logic        ack_m = 1'b0;
  logic        irq_m = 1'b0;
  logic        stray_ack = 1'b0;
  logic [7:0]  dat_m = 8'h00;
  int          wait_cnt = 0;
  int          irq_cnt = 0;
  logic        in_acc = 1'b0;
  logic [10:0] hold_acc = '0;
  int          last_cmd_ack_cyc = 0;

  vec_t vecs [8];

  wb_i2c_write_sequencer_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) sif ();

  wb_i2c_write_sequencer #(
    .WB_ADDR_WIDTH (2),
    .WB_DATA_WIDTH (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .sif  (sif.master)
  );

  assign sif.ack_i = ack_m | stray_ack;
  assign sif.irq_i = irq_m;
  assign sif.dat_i = dat_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count++;

  // Controller model: acks after ack_dly idle cycles, raises irq after each CMDR write.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_m = 1'b0; irq_m = 1'b0; in_acc = 1'b0; wait_cnt = 0; irq_cnt = 0;
    end else begin
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) irq_m = 1'b1;
      end
      if (ack_m) begin
        ack_m = 1'b0;
      end else if (sif.cyc_o && sif.stb_o) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          hold_acc = {sif.we_o, sif.adr_o, sif.dat_o};
        end else begin
          total++;
          if ({sif.we_o, sif.adr_o, sif.dat_o} !== hold_acc) begin
            bad++;
            $display("FAIL wb_stable: we/adr/dat=%03h while stb_o high, expected %03h",
                     {sif.we_o, sif.adr_o, sif.dat_o}, hold_acc);
          end
        end
        if (wait_cnt < ack_dly) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          in_acc = 1'b0;
          ack_m = 1'b1;
          if (sif.we_o) begin
            log_q.push_back({1'b1, sif.adr_o, sif.dat_o});
            if (sif.adr_o == 2'd2) begin
              last_cmd_ack_cyc = cyc_count;
              if (irq_en) irq_cnt = irq_dly;
            end
          end else begin
            log_q.push_back({1'b0, sif.adr_o, 8'h00});
            if (sif.adr_o == 2'd2) begin
              dat_m = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h80;
              irq_m = 1'b0;
            end
          end
        end
      end
    end
  end

  function automatic logic [10:0] wr(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic trace_t full_trace(input logic [7:0] b, input logic [6:0] a, input logic [7:0] d);
    trace_t t;
    t[0]  = wr(2'd1, b);
    t[1]  = wr(2'd2, 8'h06);
    t[2]  = RD_CMDR;
    t[3]  = wr(2'd2, 8'h04);
    t[4]  = RD_CMDR;
    t[5]  = wr(2'd1, {a, 1'b0});
    t[6]  = wr(2'd2, 8'h01);
    t[7]  = RD_CMDR;
    t[8]  = wr(2'd1, d);
    t[9]  = wr(2'd2, 8'h01);
    t[10] = RD_CMDR;
    t[11] = wr(2'd2, 8'h05);
    t[12] = RD_CMDR;
    return t;
  endfunction

  function automatic vec_t mk(input string nm, input logic [7:0] b, input logic [6:0] a,
                              input logic [7:0] d, input int dly, input logic [7:0] r0,
                              input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3,
                              input logic [7:0] r4, input int tlen, input logic [1:0] st);
    vec_t v;
    v.name = nm; v.b = b; v.a = a; v.d = d; v.dly = dly;
    v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3; v.resp[4] = r4;
    v.tlen = tlen; v.trace = full_trace(b, a, d); v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_csr();
    int n = 0;
    while (log_q.size() < 1 && n < 100) begin @(negedge clk); n++; end
    chk("csr_write_seen", 32'(log_q.size() >= 1), 1);
    if (log_q.size() >= 1) chk("csr_write", log_q[0], wr(2'd0, 8'hC0));
    n = 0;
    while (sif.req_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ready_after_csr", sif.req_ready_o, 1);
    $display("enable: CSR write seen, req_ready_o=%b", sif.req_ready_o);
  endtask

  task automatic start_req(input logic [7:0] b, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    while (sif.req_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("ready_before_req", sif.req_ready_o, 1);
    sif.req_bus_i = b; sif.req_addr_i = a; sif.req_data_i = d; sif.req_valid_i = 1'b1;
    @(negedge clk);
    chk("ready_busy", sif.req_ready_o, 0);
    sif.req_valid_i = 1'b0;
    sif.req_bus_i = 8'hEE; sif.req_addr_i = 7'h3C; sif.req_data_i = 8'h99;
  endtask

  task automatic wait_done(output logic [1:0] st, output int dc);
    int n = 0;
    while (sif.done_o !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (sif.done_o !== 1'b1) begin
      bad++;
      $display("FAIL done_seen: done_o=%b after %0d cycles, expected 1", sif.done_o, n);
    end
    st = sif.status_o;
    dc = cyc_count;
    @(negedge clk);
    chk("done_one_cycle", sif.done_o, 0);
    chk("ready_after_done", sif.req_ready_o, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] st;
    int dc;
    resp_q.delete();
    for (int i = 0; i < 5; i++) resp_q.push_back(v.resp[i]);
    ack_dly = v.dly;
    log_q.delete();
    start_req(v.b, v.a, v.d);
    wait_done(st, dc);
    chk({v.name, "_status"}, st, v.st);
    chk({v.name, "_trace_len"}, log_q.size(), v.tlen);
    for (int i = 0; i < v.tlen && i < log_q.size(); i++)
      chk($sformatf("%s_trace[%0d]", v.name, i), log_q[i], v.trace[i]);
    $display("req %s: bus=%02h addr=%02h data=%02h status=%0d accesses=%0d",
             v.name, v.b, v.a, v.d, st, log_q.size());
  endtask

  initial begin
    logic [1:0] st;
    int dc;
    int n;

    vecs[0] = mk("basic",       8'h05, 7'h22, 8'h78, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 13, 2'b00);
    vecs[1] = mk("nak_addr",    8'h01, 7'h50, 8'hA5, 0, 8'h80, 8'h80, 8'h40, 8'h80, 8'h80, 10, 2'b01);
    vecs[1].trace[8] = wr(2'd2, 8'h05);
    vecs[1].trace[9] = RD_CMDR;
    vecs[2] = mk("al_start",    8'h02, 7'h10, 8'h33, 0, 8'h80, 8'h20, 8'h80, 8'h80, 8'h80, 5,  2'b10);
    vecs[3] = mk("slow_ack",    8'h05, 7'h22, 8'h78, 5, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 13, 2'b00);
    vecs[4] = mk("nak_data",    8'h03, 7'h7F, 8'h00, 0, 8'h80, 8'h80, 8'h80, 8'hC0, 8'h80, 13, 2'b01);
    vecs[5] = mk("nak_setbus",  8'h06, 7'h01, 8'h11, 0, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80, 3,  2'b10);
    vecs[6] = mk("al_over_nak", 8'h07, 7'h2A, 8'h5C, 0, 8'h80, 8'h80, 8'h60, 8'h80, 8'h80, 8,  2'b10);
    vecs[7] = mk("err_stop",    8'h00, 7'h55, 8'hFF, 0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10, 13, 2'b10);

    sif.req_valid_i = 1'b0; sif.req_bus_i = '0; sif.req_addr_i = '0; sif.req_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", sif.cyc_o, 0);
    chk("rst_stb", sif.stb_o, 0);
    chk("rst_we", sif.we_o, 0);
    chk("rst_done", sif.done_o, 0);
    chk("rst_ready", sif.req_ready_o, 0);
    chk("rst_adr", sif.adr_o, 0);
    chk("rst_dat", sif.dat_o, 0);
    chk("rst_status", sif.status_o, 0);
    rst_n = 1'b1;
    wait_csr();

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);
    ack_dly = 0;

    // Stray ack while idle must not start or disturb anything.
    log_q.delete();
    #1 stray_ack = 1'b1;
    @(negedge clk);
    #1 stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_cyc", sif.cyc_o, 0);
    chk("stray_ack_ready", sif.req_ready_o, 1);
    chk("stray_ack_done", sif.done_o, 0);
    chk("stray_ack_trace", log_q.size(), 0);
    $display("req stray_ack: cyc_o=%b req_ready_o=%b", sif.cyc_o, sif.req_ready_o);

    // Timeout: no irq after Set Bus, done_o 16 cycles after WAIT entry.
    irq_en = 1'b0;
    resp_q.delete();
    log_q.delete();
    start_req(8'h09, 7'h11, 8'h22);
    wait_done(st, dc);
    chk("timeout_status", st, 2'b11);
    chk("timeout_latency", dc - (last_cmd_ack_cyc + 1), 16);
    chk("timeout_cyc", sif.cyc_o, 0);
    repeat (4) @(negedge clk);
    chk("timeout_trace_len", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("timeout_trace[0]", log_q[0], wr(2'd1, 8'h09));
      chk("timeout_trace[1]", log_q[1], wr(2'd2, 8'h06));
    end
    $display("req timeout: status=%0d latency=%0d accesses=%0d", st, dc - (last_cmd_ack_cyc + 1), log_q.size());
    irq_en = 1'b1;

    // Reset asserted while the data-phase CMDR write is held waiting for ack.
    ack_dly = 5;
    resp_q.delete();
    log_q.delete();
    start_req(8'h05, 7'h22, 8'h78);
    n = 0;
    while (log_q.size() < 9 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (sif.cyc_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("rst_mid_cyc_high", sif.cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc_drop", sif.cyc_o, 0);
    chk("rst_mid_stb_drop", sif.stb_o, 0);
    chk("rst_mid_ready", sif.req_ready_o, 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    ack_dly = 0;
    rst_n = 1'b1;
    $display("req reset_mid: reset pulsed during pending data command write");
    wait_csr();
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
